// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, digit-entry layout and FSM encodings for the front-panel scanner.
// Collects the blank pattern, entry field widths and the clog2 helper in one place.
package seg_scan_ctrl_pkg;

   localparam logic [6:0] SEG_BLANK   = 7'h7F;
   localparam int         DIGIT_VAL_W = 3;

   localparam logic [0:0] ST_DARK = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   typedef struct packed {
      logic                   blank;
      logic [DIGIT_VAL_W-1:0] value;
   } digit_t;

   localparam digit_t DIGIT_RESET = '{blank: 1'b1, value: '0};

   // Never narrower than one bit, so two-entry tables still get an index bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_bcd3bit.sv
// Combinational 3-bit digit to active-low 7-segment decoder, output as {s6..s0}.
module seg_scan_ctrl_bcd3bit (
   input  logic [2:0] value,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      case (value)
         3'd0: seg = 7'h08;
         3'd1: seg = 7'h6D;
         3'd2: seg = 7'h22;
         3'd3: seg = 7'h24;
         3'd4: seg = 7'h45;
         3'd5: seg = 7'h14;
         3'd6: seg = 7'h10;
         3'd7: seg = 7'h2D;
         default: seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed digit scanner: double-buffered digit file, dwell/guard slot timing,
// atomic frame commit and registered active-low anode/segment drive.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DWELL      = 1024,
   parameter int GUARD      = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                en,
   input  logic                                wr_en,
   input  logic [clog2_min1(NUM_DIGITS)-1:0]   wr_addr,
   input  logic [2:0]                          wr_data,
   input  logic                                wr_blank,
   input  logic                                commit,
   output logic                                pending,
   output logic                                frame_done,
   output logic [NUM_DIGITS-1:0]               an,
   output logic [6:0]                          seg
);

   localparam int IDX_W = clog2_min1(NUM_DIGITS);
   localparam int CNT_W = clog2_min1(DWELL);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [0:0]             state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [IDX_W-1:0]       idx_reg, idx_next;
   logic                   pending_reg, pending_next;
   logic                   frame_done_reg;
   logic [NUM_DIGITS-1:0]  an_reg, an_next;
   logic [6:0]             seg_reg, seg_next;

   digit_t [NUM_DIGITS-1:0] active_vec;
   digit_t                  cur_digit;
   logic                    boundary;
   logic                    transfer;
   logic                    show;
   logic [6:0]              dec_seg;

   // Slot timing: both counters clear whenever the display goes dark.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      if (!en) begin
         state_next = ST_DARK;
         cnt_next   = '0;
         idx_next   = '0;
      end else if (state_reg == ST_DARK) begin
         state_next = ST_SCAN;
         cnt_next   = '0;
         idx_next   = '0;
      end else if (cnt_reg == CNT_LAST) begin
         cnt_next = '0;
         idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   assign boundary = (state_reg == ST_SCAN) && (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);

   // While dark there is no frame to tear, so a pending commit lands immediately.
   assign transfer = ((state_reg == ST_DARK) && pending_reg) ||
                     (boundary && (pending_reg || commit));

   assign pending_next = transfer ? 1'b0 : (pending_reg || commit);

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      digit_t shadow_reg;
      digit_t active_reg;

      // Active copies the pre-write shadow, so a same-cycle write waits for the next commit.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            shadow_reg <= DIGIT_RESET;
            active_reg <= DIGIT_RESET;
         end else begin
            if (transfer) begin
               active_reg <= shadow_reg;
            end
            if (wr_en && (wr_addr == IDX_W'(gi))) begin
               shadow_reg <= '{blank: wr_blank, value: wr_data};
            end
         end
      end

      assign active_vec[gi] = active_reg;
   end

   assign cur_digit = active_vec[idx_reg];

   seg_scan_ctrl_bcd3bit u_dec (
      .value (cur_digit.value),
      .seg   (dec_seg)
   );

   assign show = (state_reg == ST_SCAN) && (cnt_reg >= CNT_GUARD) && !cur_digit.blank;

   always_comb begin
      an_next = '1;
      if (show) begin
         an_next[idx_reg] = 1'b0;
      end
      seg_next = show ? dec_seg : SEG_BLANK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_DARK;
         cnt_reg        <= '0;
         idx_reg        <= '0;
         pending_reg    <= 1'b0;
         frame_done_reg <= 1'b0;
         an_reg         <= '1;
         seg_reg        <= SEG_BLANK;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         idx_reg        <= idx_next;
         pending_reg    <= pending_next;
         frame_done_reg <= transfer;
         an_reg         <= an_next;
         seg_reg        <= seg_next;
      end
   end

   assign pending    = pending_reg;
   assign frame_done = frame_done_reg;
   assign an         = an_reg;
   assign seg        = seg_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (4 digits, dwell 8, guard 1): directed table, hand sequences
// and random traffic checked against a time-based reference model.
module tb_seg_scan_ctrl;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int GD    = 1;
   localparam int FRAME = N * DW;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = 2'd0;
   logic [2:0] wr_data = 3'd0;
   logic       wr_blank = 1'b0;
   logic       commit = 1'b0;
   logic       pending;
   logic       frame_done;
   logic [3:0] an;
   logic [6:0] seg;

   int tests = 0;
   int fails = 0;

   seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL(DW), .GUARD(GD)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_blank   (wr_blank),
      .commit     (commit),
      .pending    (pending),
      .frame_done (frame_done),
      .an         (an),
      .seg        (seg)
   );

   always #5 clk = ~clk;

   // Reference model: slot position derived from cycles elapsed since scanning began.
   typedef struct packed {
      logic       blank;
      logic [2:0] value;
   } ent_t;

   ent_t       m_shadow [N];
   ent_t       m_active [N];
   bit         m_scan;
   int         m_age;
   bit         m_pend;
   bit         m_fd;
   logic [3:0] m_an;
   logic [6:0] m_seg;
   logic [6:0] dec_tab [8];

   task automatic model_reset();
      m_scan = 0;
      m_age  = 0;
      m_pend = 0;
      m_fd   = 0;
      m_an   = 4'hF;
      m_seg  = 7'h7F;
      for (int i = 0; i < N; i++) begin
         m_shadow[i] = '{blank: 1'b1, value: 3'd0};
         m_active[i] = '{blank: 1'b1, value: 3'd0};
      end
   endtask

   task automatic model_edge();
      int  pos;
      int  digit;
      bit  lit;
      bit  at_boundary;
      bit  xfer;
      if (rst) begin
         model_reset();
         return;
      end
      pos         = m_age % DW;
      digit       = (m_age / DW) % N;
      lit         = m_scan && (pos >= GD) && !m_active[digit].blank;
      m_an        = lit ? ~(4'b0001 << digit) : 4'hF;
      m_seg       = lit ? dec_tab[m_active[digit].value] : 7'h7F;
      at_boundary = m_scan && ((m_age % FRAME) == FRAME - 1);
      xfer        = (!m_scan && m_pend) || (at_boundary && (m_pend || commit));
      m_fd        = xfer;
      m_pend      = xfer ? 1'b0 : (m_pend || commit);
      if (xfer) m_active = m_shadow;
      if (wr_en) m_shadow[wr_addr] = '{blank: wr_blank, value: wr_data};
      if (!en) begin
         m_scan = 0;
         m_age  = 0;
      end else if (!m_scan) begin
         m_scan = 1;
         m_age  = 0;
      end else begin
         m_age++;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
      check("model_an", 32'(an), 32'(m_an));
      check("model_seg", 32'(seg), 32'(m_seg));
      check("model_pending", 32'(pending), 32'(m_pend));
      check("model_frame_done", 32'(frame_done), 32'(m_fd));
   endtask

   // Bounded: the model age advances every cycle while scanning.
   task automatic run_to_age(input int target);
      for (int k = 0; k < 2 * FRAME; k++) begin
         if ((m_age % FRAME) == target) return;
         tick();
      end
      check("run_to_age_reached", 32'(m_age % FRAME), 32'(target));
   endtask

   task automatic idle_inputs();
      wr_en  = 1'b0;
      commit = 1'b0;
   endtask

   typedef struct {
      logic       en;
      logic       wr_en;
      logic [1:0] addr;
      logic [2:0] data;
      logic       blank;
      logic       commit;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_pend;
      logic       exp_fd;
   } vec_t;

   vec_t vecs [8];

   logic [3:0] an_log  [51];
   logic [6:0] seg_log [51];
   logic       fd_log  [51];
   logic       pnd_log [51];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;

      dec_tab[0] = 7'h08; dec_tab[1] = 7'h6D; dec_tab[2] = 7'h22; dec_tab[3] = 7'h24;
      dec_tab[4] = 7'h45; dec_tab[5] = 7'h14; dec_tab[6] = 7'h10; dec_tab[7] = 7'h2D;

      // Dark-mode commits: transfer lands one cycle after commit, repeated commit is absorbed.
      vecs[0] = '{1'b0, 1'b1, 2'd2, 3'd6, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 4'hF, 7'h7F, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 4'hF, 7'h7F, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 4'hF, 7'h7F, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b0, 1'b0};

      model_reset();

      // Reset state
      for (int i = 0; i < 3; i++) tick();
      check("reset_an", 32'(an), 32'h0000000F);
      check("reset_seg", 32'(seg), 32'h0000007F);
      check("reset_pending", 32'(pending), 32'd0);
      check("reset_frame_done", 32'(frame_done), 32'd0);
      rst = 1'b0;

      // Scanning with nothing written stays dark
      en  = 1'b1;
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (an !== 4'hF || seg !== 7'h7F) cnt++;
      end
      check("unwritten_lit_cycles", 32'(cnt), 32'd0);

      en = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         en       = vecs[i].en;
         wr_en    = vecs[i].wr_en;
         wr_addr  = vecs[i].addr;
         wr_data  = vecs[i].data;
         wr_blank = vecs[i].blank;
         commit   = vecs[i].commit;
         tick();
         check($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].exp_an));
         check($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].exp_seg));
         check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pend));
         check($sformatf("vec%0d_frame_done", i), 32'(frame_done), 32'(vecs[i].exp_fd));
      end
      idle_inputs();

      // Write 3,1,4,7 then commit together with en rising
      for (int d = 0; d < 4; d++) begin
         wr_en    = 1'b1;
         wr_addr  = 2'(d);
         wr_data  = (d == 0) ? 3'd3 : (d == 1) ? 3'd1 : (d == 2) ? 3'd4 : 3'd7;
         wr_blank = 1'b0;
         tick();
      end
      wr_en  = 1'b0;
      en     = 1'b1;
      commit = 1'b1;
      tick();
      commit = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         tick();
         an_log[k]  = an;
         seg_log[k] = seg;
         fd_log[k]  = frame_done;
         pnd_log[k] = pending;
      end
      cnt = 0;
      for (int k = 1; k <= 50; k++) if (fd_log[k]) cnt++;
      check("first_frame_fd_count", 32'(cnt), 32'd1);
      check("first_frame_fd_at_boundary", 32'(fd_log[32]), 32'd1);
      check("pending_before_boundary", 32'(pnd_log[31]), 32'd1);
      check("pending_after_boundary", 32'(pnd_log[32]), 32'd0);
      check("digit0_guard_an", 32'(an_log[33]), 32'h0000000F);
      cnt = 0;
      for (int k = 34; k <= 40; k++) if (an_log[k] === 4'hE && seg_log[k] === 7'h24) cnt++;
      check("digit0_lit_cycles", 32'(cnt), 32'd7);
      check("digit1_guard_an", 32'(an_log[41]), 32'h0000000F);
      check("digit1_an", 32'(an_log[42]), 32'h0000000D);
      check("digit1_seg", 32'(seg_log[42]), 32'h0000006D);

      // Commit on the boundary cycle with a simultaneous write to digit 2
      wr_en    = 1'b1;
      wr_addr  = 2'd2;
      wr_data  = 3'd6;
      wr_blank = 1'b0;
      tick();
      wr_en = 1'b0;
      run_to_age(FRAME - 1);
      commit  = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 2'd2;
      wr_data = 3'd5;
      tick();
      idle_inputs();
      check("boundary_commit_fd", 32'(frame_done), 32'd1);
      check("boundary_commit_pending", 32'(pending), 32'd0);
      run_to_age(19);
      check("digit2_old_an", 32'(an), 32'h0000000B);
      check("digit2_old_seg", 32'(seg), 32'h00000010);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      run_to_age(FRAME - 1);
      tick();
      check("second_commit_fd", 32'(frame_done), 32'd1);
      run_to_age(19);
      check("digit2_new_an", 32'(an), 32'h0000000B);
      check("digit2_new_seg", 32'(seg), 32'h00000014);

      // Asynchronous reset mid-slot with a commit pending
      run_to_age(12);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      check("pending_before_rst", 32'(pending), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_an", 32'(an), 32'h0000000F);
      check("async_rst_seg", 32'(seg), 32'h0000007F);
      check("async_rst_pending", 32'(pending), 32'd0);
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (frame_done) cnt++;
      end
      check("no_fd_after_rst", 32'(cnt), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(49) == 0) en = ~en;
         wr_en    = ($urandom_range(3) == 0);
         wr_addr  = 2'($urandom_range(3));
         wr_data  = 3'($urandom_range(7));
         wr_blank = ($urandom_range(3) == 0);
         commit   = ($urandom_range(29) == 0);
         rst      = ($urandom_range(399) == 0);
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
